mult16_final_cpa: RTL

- Downstream consumer of the 16x16 multiplier's partial-product compression slices.
- Takes the redundant sum/carry vector pair produced by the compressor tree and resolves it to the 32-bit binary product.
- Uses a 2-stage pipelined carry-propagate adder (low half, then high half), with valid/ready handshakes on both sides.
- Sits between the compressor partitions and the multiplier output register.

---
 rtl/mult16_final_cpa.sv | 97 +++++++++
 1 files changed

// File: rtl/mult16_final_cpa.sv
// Final carry-propagate adder for the 16x16 multiplier.
// Resolves the compressor tree's redundant sum/carry pair into the binary
// product using a two-stage pipelined adder (low half, then high half) with
// valid/ready handshakes on both sides and a saturating delivered-product count.
module mult16_final_cpa #(
    parameter int unsigned W    = 32,
    parameter int unsigned LO   = 16,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_sum,
    input  logic [W-1:0]    in_carry,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_prod,
    output logic [CNTW-1:0] out_count
);

    localparam int unsigned HI = W - LO;

    // Stage 1: resolved low half plus the untouched high-half vectors
    logic          s1_v;
    logic [LO-1:0] s1_lo;
    logic          s1_c;
    logic [HI-1:0] s1_sum_hi;
    logic [HI-1:0] s1_carry_hi;

    // Stage 2: full product
    logic          s2_v;
    logic [W-1:0]  s2_prod;

    logic          adv1;
    logic          adv2;
    logic          in_xfer;
    logic          out_xfer;
    logic [LO:0]   lo_add;
    logic [HI-1:0] hi_add;

    // Handshake, advance and adder datapath
    always_comb begin
        adv2     = ~s2_v | out_ready;
        adv1     = s1_v & adv2;
        in_ready = ~s1_v | adv2;
        in_xfer  = in_valid & in_ready;
        out_xfer = s2_v & out_ready;
        lo_add   = {1'b0, in_sum[LO-1:0]} + {1'b0, in_carry[LO-1:0]};
        hi_add   = s1_sum_hi + s1_carry_hi + {{(HI-1){1'b0}}, s1_c};
    end

    // Stage 1 register: loads on input transfer, empties when drained into stage 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v        <= 1'b0;
            s1_lo       <= '0;
            s1_c        <= 1'b0;
            s1_sum_hi   <= '0;
            s1_carry_hi <= '0;
        end else if (in_xfer) begin
            s1_v        <= 1'b1;
            s1_lo       <= lo_add[LO-1:0];
            s1_c        <= lo_add[LO];
            s1_sum_hi   <= in_sum[W-1:LO];
            s1_carry_hi <= in_carry[W-1:LO];
        end else if (adv1) begin
            s1_v <= 1'b0;
        end
    end

    // Stage 2 register: completes the high half; final carry-out is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_prod <= '0;
        end else if (adv1) begin
            s2_v    <= 1'b1;
            s2_prod <= {hi_add, s1_lo};
        end else if (out_xfer) begin
            s2_v <= 1'b0;
        end
    end

    // Delivered-product counter, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (out_xfer && (out_count != '1)) begin
            out_count <= out_count + CNTW'(1);
        end
    end

    assign out_valid = s2_v;
    assign out_prod  = s2_prod;

endmodule
